mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master, one-slave arbiter for the PicoRV32 native memory interface. It shares the single `bram_controller` between the CPU (master 0) and a program loader or debug monitor (master 1). It replaces ad-hoc muxing of the memory bus with registered grants, one-transaction locking and a slave-timeout watchdog.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles in BUSY before a forced completion. 0 disables the watchdog.
- `TIMEOUT_RDATA`, default 32'hDEADBEEF: read data returned on a forced completion.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `m0_valid`, `m0_instr` in 1 each: master 0 request and instruction-fetch flag.
- `m0_addr`, `m0_wdata` in 32 each: master 0 address and write data.
- `m0_wstrb` in 4: master 0 byte strobes; 0 means read.
- `m0_ready` out 1: master 0 completion pulse.
- `m0_rdata` out 32: master 0 read data.
- `m1_*` (same set): master 1, identical widths and directions.
- `s_valid`, `s_instr` out 1 each: request to the memory slave.
- `s_addr`, `s_wdata` out 32 each: address and write data to the slave.
- `s_wstrb` out 4: byte strobes to the slave.
- `s_ready` in 1: slave completion.
- `s_rdata` in 32: slave read data.
- `grant` out 2: one-hot current owner; bit 0 is master 0, bit 1 is master 1.
- `timeout_err` out 1: one-cycle pulse on a forced completion.

## Operation
- FSM states: IDLE and BUSY. Registers: `state`, `grant`, `last` (last master served), `tcnt` (timeout counter).
- **IDLE arbitration:**
  - Only one `mX_valid` is high: that master wins.
  - Both are high: the winner is chosen per Configuration.
  - Neither is high: stay in IDLE.
  - On a win, the next edge loads `grant`, updates `last`, clears `tcnt` and enters BUSY.
- **BUSY routing (combinational from registered `grant`):**
  - `s_valid` = granted `mX_valid`.
  - `s_instr`, `s_addr`, `s_wdata` and `s_wstrb` come from the granted master.
  - Granted `mX_ready` = `s_ready`.
  - The non-granted master's `ready` stays 0.
  - `m0_rdata` and `m1_rdata` both carry `s_rdata`, except on a timeout pulse (see below).
- **No grant:** `s_valid`, `s_instr`, `s_addr`, `s_wdata` and `s_wstrb` are all 0.
- **BUSY exits:**
  - `s_ready` = 1: transaction complete; next edge goes to IDLE and clears `grant`.
  - Granted `mX_valid` drops before `s_ready` (abort): next edge goes to IDLE and clears `grant`. No ready is issued.
  - `TIMEOUT_CYCLES` ≠ 0 and `tcnt` == `TIMEOUT_CYCLES`−1 with `s_ready` = 0:
    - In that cycle the granted `mX_ready` = 1, its `mX_rdata` = `TIMEOUT_RDATA`, and `timeout_err` = 1.
    - `s_valid` is forced to 0 in that cycle.
    - Next edge goes to IDLE.
  - Otherwise `tcnt` increments.
- **Simultaneous events:** `s_ready` and the timeout in the same cycle means normal completion; `timeout_err` stays 0.
- **Width of `tcnt`:** `$clog2(TIMEOUT_CYCLES+1)` bits, minimum 1. It never wraps, because the exit happens at the terminal count.
- **Reset, including mid-transaction:**
  - `state` = IDLE, `grant` = 0, `tcnt` = 0, `last` = master 1.
  - Every output is 0 from the cycle after reset is sampled.
  - Any in-flight transaction is dropped without a ready.

## Timing
- Arbitration latency: one cycle. A `valid` sampled in IDLE at edge N gives `s_valid` in cycle N+1.
- Completion: `mX_ready` arrives in the same cycle as `s_ready`, with zero added latency.
- Turnaround: at least one IDLE cycle between transactions. Back-to-back throughput is one access per (slave latency + 2) cycles.
- Masters hold `valid` and their payload until `ready` (PicoRV32 rule). The arbiter never changes owner mid-transaction.

## Configuration
- `MEM_ARBITER_ROUND_ROBIN_EN` defined: on a tie, the master not equal to `last` wins. After reset, master 0 wins the first tie.
- Undefined: fixed priority, master 1 (loader/monitor) always wins ties. `last` is still maintained but does not affect the decision.

## Test plan
- **Single read:** master 0 reads 0x400 with a 1-cycle-latency slave returning 42.
  - `grant` = 01 the cycle after valid.
  - `m0_ready` pulses with `m0_rdata` = 42.
  - Back in IDLE the next cycle.
- **Tie:** both masters request together (write 0x404 = 0x12345014; read 0x0).
  - Without the macro, master 1 is served first.
  - With the macro, master 0 first, then master 1, with one IDLE cycle between.
  - Neither master ever sees a spurious `ready`.
- **Timeout:** `TIMEOUT_CYCLES` = 4 and the slave never readies.
  - `m0_ready` = 1 with `m0_rdata` = 32'hDEADBEEF in the 4th BUSY cycle.
  - `timeout_err` pulses once and `s_valid` = 0 in that cycle.
- **Abort:** master 1 drops `valid` in its 2nd BUSY cycle.
  - `s_valid` falls in the same cycle.
  - IDLE at the next edge, with no `m1_ready`.
- **Reset mid-transaction:** `reset` asserted during BUSY.
  - Next cycle all outputs are 0 and `grant` = 00.
  - A fresh master 0 request after reset is granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master / one-slave arbiter for the PicoRV32 native memory bus.
// Master 0 is the CPU and master 1 is the loader/monitor. Grants are registered,
// a grant is held for exactly one transaction, and a watchdog forces completion
// when the slave stalls.
// Latency: one cycle from an IDLE valid to s_valid; ready is passed through with
// no added delay. There is at least one IDLE cycle between transactions.
// Backpressure: a master holds valid and its payload until its ready. The loser
// of arbitration simply waits.
// Ports: clk, reset (sync, active-high); m0_*/m1_* master request/response sets;
//        s_* slave request/response; grant (one-hot owner); timeout_err (pulse).
// Build option: define MEM_ARBITER_ROUND_ROBIN_EN for round-robin tie-breaking.
//               Otherwise master 1 wins every tie.
module mem_arbiter #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  localparam int TW   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int TMAX = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [TW-1:0] TLAST = TMAX[TW-1:0];
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [1:0]      grant_nxt;
  logic            last, last_nxt;   // 0 = master 0 served last, 1 = master 1
  logic [TW-1:0]   tcnt, tcnt_nxt;
  logic            gvalid;
  logic            timeout_hit;
  logic            pick_m1;
  logic            tie_m1;

  // The owner's valid is still up. Because grant is zero in IDLE, this is
  // also zero there.
  assign gvalid = (grant[0] & m0_valid) | (grant[1] & m1_valid);

  // Watchdog fires only for a live request. If the owner has already dropped
  // valid, that is an abort, and no forced ready is given. A real s_ready in
  // the same cycle wins over the watchdog.
  assign timeout_hit = TO_EN && (state == BUSY) && gvalid && !s_ready && (tcnt == TLAST);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  assign tie_m1 = ~last;
`else
  assign tie_m1 = 1'b1;
`endif

  assign pick_m1 = m1_valid & (~m0_valid | tie_m1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= 2'b00;
      last  <= 1'b1;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
      tcnt  <= tcnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    tcnt_nxt  = tcnt;
    case (state)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          state_nxt = BUSY;
          grant_nxt = pick_m1 ? 2'b10 : 2'b01;
          last_nxt  = pick_m1;
          tcnt_nxt  = '0;
        end
      end
      BUSY: begin
        if (s_ready || !gvalid || timeout_hit) begin
          state_nxt = IDLE;
          grant_nxt = 2'b00;
        end else if (TO_EN) begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  // Output logic: routing is a pure function of the registered grant.
  always_comb begin
    s_valid     = gvalid & ~timeout_hit;
    s_instr     = 1'b0;
    s_addr      = 32'h0;
    s_wdata     = 32'h0;
    s_wstrb     = 4'h0;
    if (grant[0]) begin
      s_instr = m0_instr;
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
      s_wstrb = m0_wstrb;
    end else if (grant[1]) begin
      s_instr = m1_instr;
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
      s_wstrb = m1_wstrb;
    end
    m0_ready    = grant[0] & (s_ready | timeout_hit);
    m1_ready    = grant[1] & (s_ready | timeout_hit);
    m0_rdata    = (grant[0] & timeout_hit) ? TIMEOUT_RDATA : s_rdata;
    m1_rdata    = (grant[1] & timeout_hit) ? TIMEOUT_RDATA : s_rdata;
    timeout_err = timeout_hit;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m0_instr, m0_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic        m1_valid, m1_instr, m1_ready;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic        s_valid, s_instr, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  localparam logic [1:0] FIRST_G  = 2'b01;
  localparam logic [1:0] SECOND_G = 2'b10;
`else
  localparam logic [1:0] FIRST_G  = 2'b10;
  localparam logic [1:0] SECOND_G = 2'b01;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(4), .TIMEOUT_RDATA(32'hDEADBEEF)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive point: just after the rising edge. Checks happen on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    s_ready = 0; s_rdata = 0;

    // ---- reset state
    tick(); tick();
    sample();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_s_valid", 32'(s_valid), 32'h0);
    check("rst_m0_ready", 32'(m0_ready), 32'h0);
    check("rst_timeout", 32'(timeout_err), 32'h0);
    tick();
    reset = 1'b0;

    // ---- single read by master 0
    m0_valid = 1; m0_addr = 32'h400; m0_wstrb = 4'h0;
    sample();
    check("rd_idle_s_valid", 32'(s_valid), 32'h0);
    tick();
    sample();
    check("rd_grant", 32'(grant), 32'h1);
    check("rd_s_valid", 32'(s_valid), 32'h1);
    check("rd_s_addr", s_addr, 32'h400);
    check("rd_m0_ready_early", 32'(m0_ready), 32'h0);
    tick();
    s_ready = 1; s_rdata = 32'd42;
    sample();
    check("rd_m0_ready", 32'(m0_ready), 32'h1);
    check("rd_m0_rdata", m0_rdata, 32'd42);
    check("rd_m1_ready", 32'(m1_ready), 32'h0);
    tick();
    m0_valid = 0; s_ready = 0; s_rdata = 0;
    sample();
    check("rd_back_idle", 32'(grant), 32'h0);
    check("rd_idle_s_valid2", 32'(s_valid), 32'h0);

    // ---- tie, from a fresh reset so the round-robin pointer is at its reset value
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m0_valid = 1; m0_addr = 32'h404; m0_wdata = 32'h12345014; m0_wstrb = 4'hF;
    m1_valid = 1; m1_addr = 32'h0;   m1_wstrb = 4'h0;
    tick();
    sample();
    check("tie1_grant", 32'(grant), 32'(FIRST_G));
    check("tie1_s_addr", s_addr, (FIRST_G == 2'b01) ? 32'h404 : 32'h0);
    check("tie1_s_wstrb", 32'(s_wstrb), (FIRST_G == 2'b01) ? 32'hF : 32'h0);
    check("tie1_no_ready", 32'({m1_ready, m0_ready}), 32'h0);
    tick();
    s_ready = 1;
    sample();
    check("tie1_ready", 32'({m1_ready, m0_ready}), 32'(FIRST_G));
    tick();
    s_ready = 0;
    if (FIRST_G == 2'b01) m0_valid = 0; else m1_valid = 0;
    sample();
    check("tie_gap_grant", 32'(grant), 32'h0);
    check("tie_gap_ready", 32'({m1_ready, m0_ready}), 32'h0);
    tick();
    sample();
    check("tie2_grant", 32'(grant), 32'(SECOND_G));
    check("tie2_s_addr", s_addr, (SECOND_G == 2'b01) ? 32'h404 : 32'h0);
    check("tie2_no_ready", 32'({m1_ready, m0_ready}), 32'h0);
    tick();
    s_ready = 1;
    sample();
    check("tie2_ready", 32'({m1_ready, m0_ready}), 32'(SECOND_G));
    tick();
    s_ready = 0; m0_valid = 0; m1_valid = 0;
    m0_wstrb = 0; m0_wdata = 0;
    sample();
    check("tie_end_grant", 32'(grant), 32'h0);

    // ---- timeout: the slave never responds
    m0_valid = 1; m0_addr = 32'h8; s_rdata = 32'h1111;
    tick();           // BUSY cycle 1
    sample();
    check("to_b1_s_valid", 32'(s_valid), 32'h1);
    check("to_b1_err", 32'(timeout_err), 32'h0);
    tick();           // BUSY cycle 2
    tick();           // BUSY cycle 3
    sample();
    check("to_b3_err", 32'(timeout_err), 32'h0);
    check("to_b3_ready", 32'(m0_ready), 32'h0);
    tick();           // BUSY cycle 4: forced completion
    sample();
    check("to_ready", 32'(m0_ready), 32'h1);
    check("to_rdata", m0_rdata, 32'hDEADBEEF);
    check("to_err", 32'(timeout_err), 32'h1);
    check("to_s_valid", 32'(s_valid), 32'h0);
    check("to_m1_rdata", m1_rdata, 32'h1111);
    tick();
    m0_valid = 0;
    sample();
    check("to_after_err", 32'(timeout_err), 32'h0);
    check("to_after_grant", 32'(grant), 32'h0);
    s_rdata = 0;

    // ---- abort by master 1
    m1_valid = 1; m1_addr = 32'h10;
    tick();
    sample();
    check("ab_grant", 32'(grant), 32'h2);
    check("ab_s_valid", 32'(s_valid), 32'h1);
    tick();
    m1_valid = 0;
    sample();
    check("ab_s_valid_drop", 32'(s_valid), 32'h0);
    check("ab_no_ready", 32'(m1_ready), 32'h0);
    tick();
    sample();
    check("ab_idle_grant", 32'(grant), 32'h0);
    check("ab_idle_ready", 32'(m1_ready), 32'h0);

    // ---- reset in the middle of a transaction
    m0_valid = 1; m0_addr = 32'h20;
    tick();
    sample();
    check("rm_grant", 32'(grant), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sample();
    check("rm_grant_clr", 32'(grant), 32'h0);
    check("rm_s_valid", 32'(s_valid), 32'h0);
    check("rm_s_addr", s_addr, 32'h0);
    check("rm_ready", 32'({m1_ready, m0_ready}), 32'h0);
    check("rm_rdata", m0_rdata | m1_rdata, 32'h0);
    check("rm_err", 32'(timeout_err), 32'h0);
    tick();
    sample();
    check("rm_regrant", 32'(grant), 32'h1);
    check("rm_regrant_addr", s_addr, 32'h20);
    tick();
    s_ready = 1; s_rdata = 32'h77;
    sample();
    check("rm_ready_after", 32'(m0_ready), 32'h1);
    check("rm_rdata_after", m0_rdata, 32'h77);
    tick();
    s_ready = 0; m0_valid = 0;
    sample();
    check("rm_end_grant", 32'(grant), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
